// File: rtl/operand_feeder.sv
// Operand feeder: in-order FIFO of operand pairs with registered outputs toward a logic-op stage.
// Defining OPERAND_FEEDER_SWEEP_EN adds an exhaustive {MULTI,MULTI2} sweep generator.
module operand_feeder #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST_X,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [WIDTH-1:0]       IN_A,
    input  logic [WIDTH-1:0]       IN_B,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [WIDTH-1:0]       MULTI,
    output logic [WIDTH-1:0]       MULTI2,
    output logic [$clog2(DEPTH):0] COUNT
`ifdef OPERAND_FEEDER_SWEEP_EN
    ,
    input  logic                   SWEEP_START,
    output logic                   SWEEP_BUSY
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 2 * WIDTH;

`ifdef OPERAND_FEEDER_SWEEP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, SWEEP = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;
`endif

    state_t         state_r;
    state_t         state_nxt_s;
    logic [DW-1:0]  mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  rd_ptr_nxt_s;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_nxt_s;
    logic           ready_r;
    logic           ready_nxt_s;
    logic           out_valid_r;
    logic           out_valid_nxt_s;
    logic [DW-1:0]  out_pair_r;
    logic [DW-1:0]  out_pair_nxt_s;
    logic [DW-1:0]  sweep_pair_s;
    logic           sweep_nxt_s;
    logic           push_s;
    logic           pop_s;
    logic           out_xfer_s;
`ifdef OPERAND_FEEDER_SWEEP_EN
    logic [DW-1:0]  sweep_cnt_r;
    logic [DW-1:0]  sweep_cnt_nxt_s;

    assign sweep_nxt_s  = (state_nxt_s == SWEEP);
    assign sweep_pair_s = sweep_cnt_nxt_s;
    assign SWEEP_BUSY   = (state_r == SWEEP);
`else
    assign sweep_nxt_s  = 1'b0;
    assign sweep_pair_s = {DW{1'b0}};
`endif

    // Ready is held low during reset regardless of the registered fullness flag.
    assign IN_READY   = ready_r & RST_X;
    assign push_s     = IN_VALID & IN_READY;
    assign out_xfer_s = out_valid_r & OUT_READY;

    assign OUT_VALID  = out_valid_r;
    assign MULTI      = out_pair_r[DW-1:WIDTH];
    assign MULTI2     = out_pair_r[WIDTH-1:0];
    assign COUNT      = count_r;

    // Next-state logic; a push in IDLE takes priority over a sweep request.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
`ifdef OPERAND_FEEDER_SWEEP_EN
        sweep_cnt_nxt_s = sweep_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (push_s) begin
                    state_nxt_s = STREAM;
`ifdef OPERAND_FEEDER_SWEEP_EN
                end else if (SWEEP_START) begin
                    state_nxt_s = SWEEP;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                pop_s = out_xfer_s;
                if (pop_s && !push_s && (count_r == CW'(1))) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
`ifdef OPERAND_FEEDER_SWEEP_EN
            SWEEP: begin
                if (out_xfer_s) begin
                    if (sweep_cnt_r == {DW{1'b1}}) begin
                        state_nxt_s     = IDLE;
                        sweep_cnt_nxt_s = {DW{1'b0}};
                    end else begin
                        state_nxt_s     = SWEEP;
                        sweep_cnt_nxt_s = sweep_cnt_r + DW'(1);
                    end
                end else begin
                    state_nxt_s = SWEEP;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and the value the output register takes after this edge.
    always_comb begin
        rd_ptr_nxt_s    = rd_ptr_r;
        count_nxt_s     = count_r;
        out_pair_nxt_s  = {DW{1'b0}};
        out_valid_nxt_s = 1'b0;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        if (sweep_nxt_s) begin
            out_valid_nxt_s = 1'b1;
            out_pair_nxt_s  = sweep_pair_s;
        end else if (count_nxt_s != {CW{1'b0}}) begin
            out_valid_nxt_s = 1'b1;
            // The new head may be the pair being written on this very edge.
            if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                out_pair_nxt_s = {IN_A, IN_B};
            end else begin
                out_pair_nxt_s = mem_r[rd_ptr_nxt_s];
            end
        end else begin
            out_valid_nxt_s = 1'b0;
            out_pair_nxt_s  = {DW{1'b0}};
        end
        ready_nxt_s = (count_nxt_s < CW'(DEPTH)) && !sweep_nxt_s;
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            ready_r     <= 1'b1;
            out_valid_r <= 1'b0;
            out_pair_r  <= {DW{1'b0}};
`ifdef OPERAND_FEEDER_SWEEP_EN
            sweep_cnt_r <= {DW{1'b0}};
`endif
        end else begin
            state_r     <= state_nxt_s;
            wr_ptr_r    <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            ready_r     <= ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_pair_r  <= out_pair_nxt_s;
`ifdef OPERAND_FEEDER_SWEEP_EN
            sweep_cnt_r <= sweep_cnt_nxt_s;
`endif
        end
    end

    // Pair storage; entries are only read once COUNT says they were written.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {IN_A, IN_B};
        end
    end

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder: queue model of the FIFO plus an integer sweep model.
`timescale 1ns/1ps
module tb_operand_feeder;
    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NPAIR = 1 << (2 * WIDTH);

    logic             CLK = 1'b0;
    logic             RST_X;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] MULTI;
    logic [WIDTH-1:0] MULTI2;
    logic [CW-1:0]    COUNT;
`ifdef OPERAND_FEEDER_SWEEP_EN
    logic             SWEEP_START;
    logic             SWEEP_BUSY;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [2*WIDTH-1:0] m_q[$];
    bit                 m_sweep = 1'b0;
    int                 m_sweep_val = 0;
    int                 sweep_xfers = 0;
    bit                 exp_ready, exp_valid, in_x, out_x, sw_start;
    logic [2*WIDTH-1:0] exp_pair;

    always #5 CLK = ~CLK;

    operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_X      (RST_X),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_A       (IN_A),
        .IN_B       (IN_B),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .MULTI      (MULTI),
        .MULTI2     (MULTI2),
        .COUNT      (COUNT)
`ifdef OPERAND_FEEDER_SWEEP_EN
        ,
        .SWEEP_START(SWEEP_START),
        .SWEEP_BUSY (SWEEP_BUSY)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model mid-cycle, then apply the handshakes due at the next edge.
    always @(negedge CLK) begin
        if (RST_X !== 1'b1) begin
            chk("in_ready_in_reset", 32'(IN_READY), 32'd0);
            m_q.delete();
            m_sweep     = 1'b0;
            m_sweep_val = 0;
        end else begin
            exp_ready = (m_q.size() < DEPTH) && !m_sweep;
            exp_valid = (m_q.size() > 0) || m_sweep;
            if (m_sweep)
                exp_pair = m_sweep_val[2*WIDTH-1:0];
            else if (m_q.size() > 0)
                exp_pair = m_q[0];
            else
                exp_pair = '0;
            chk("in_ready", 32'(IN_READY), 32'(exp_ready));
            chk("out_valid", 32'(OUT_VALID), 32'(exp_valid));
            chk("count", 32'(COUNT), 32'(m_q.size()));
            chk("multi", 32'(MULTI), 32'(exp_pair[2*WIDTH-1:WIDTH]));
            chk("multi2", 32'(MULTI2), 32'(exp_pair[WIDTH-1:0]));
            in_x     = (IN_VALID === 1'b1) && exp_ready;
            out_x    = (OUT_READY === 1'b1) && exp_valid;
            sw_start = 1'b0;
`ifdef OPERAND_FEEDER_SWEEP_EN
            chk("sweep_busy", 32'(SWEEP_BUSY), 32'(m_sweep));
            sw_start = (SWEEP_START === 1'b1) && !m_sweep && (m_q.size() == 0) && !in_x;
`endif
            if (out_x) begin
                if (m_sweep) begin
                    sweep_xfers++;
                    if (m_sweep_val == NPAIR - 1) m_sweep = 1'b0;
                    else m_sweep_val++;
                end else begin
                    void'(m_q.pop_front());
                end
            end
            if (in_x) m_q.push_back({IN_A, IN_B});
            if (sw_start) begin
                m_sweep     = 1'b1;
                m_sweep_val = 0;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs();
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        IN_A      = '0;
        IN_B      = '0;
`ifdef OPERAND_FEEDER_SWEEP_EN
        SWEEP_START = 1'b0;
`endif
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit acc = 1'b0;
        IN_VALID = 1'b1;
        IN_A     = a;
        IN_B     = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge CLK);
            acc = (IN_READY === 1'b1);
            step();
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        bit empty = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 100 && !empty; i++) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b1) empty = 1'b1;
            else step();
        end
        if (!empty) chk("drain_timeout", 32'd0, 32'd1);
        step();
        OUT_READY = 1'b0;
    endtask

    initial begin
        RST_X = 1'b0;
        idle_inputs();
        repeat (2) step();
        RST_X = 1'b1;

        // First pair, held at the output under backpressure
        send(3'd5, 3'd2);
        repeat (2) step();
        drain();

        // Fill to DEPTH, a fifth pair waits for a single pop
        for (int i = 0; i < DEPTH; i++) send(WIDTH'($urandom), WIDTH'($urandom));
        IN_VALID = 1'b1;
        IN_A     = WIDTH'($urandom);
        IN_B     = WIDTH'($urandom);
        repeat (3) step();
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        step();
        IN_VALID = 1'b0;
        drain();

        // Steady push+pop at COUNT=2 across pointer wraps
        send(WIDTH'($urandom), WIDTH'($urandom));
        send(WIDTH'($urandom), WIDTH'($urandom));
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            IN_A = WIDTH'($urandom);
            IN_B = WIDTH'($urandom);
            step();
        end
        IN_VALID = 1'b0;
        drain();

        // Reset with three pairs stored
        for (int i = 0; i < 3; i++) send(WIDTH'($urandom), WIDTH'($urandom));
        RST_X = 1'b0;
        step();
        RST_X = 1'b1;
        repeat (2) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            IN_VALID  = 1'($urandom_range(0, 1));
            OUT_READY = 1'($urandom_range(0, 1));
            IN_A      = WIDTH'($urandom);
            IN_B      = WIDTH'($urandom);
            step();
        end
        idle_inputs();
        drain();

`ifdef OPERAND_FEEDER_SWEEP_EN
        // Full sweep with mild backpressure and input attempts that must be refused
        SWEEP_START = 1'b1;
        OUT_READY   = 1'b1;
        step();
        SWEEP_START = 1'b0;
        begin
            bit ended = 1'b0;
            for (int i = 0; i < 300 && !ended; i++) begin
                OUT_READY = ($urandom_range(0, 3) != 0);
                IN_VALID  = 1'($urandom_range(0, 1));
                IN_A      = WIDTH'($urandom);
                IN_B      = WIDTH'($urandom);
                step();
                if (SWEEP_BUSY !== 1'b1) ended = 1'b1;
            end
            if (!ended) chk("sweep_timeout", 32'd0, 32'd1);
        end
        idle_inputs();
        step();
        chk("sweep_transfers", 32'(sweep_xfers), 32'(NPAIR));

        // Sweep request while a pair is stored is ignored
        send(3'd3, 3'd4);
        SWEEP_START = 1'b1;
        step();
        SWEEP_START = 1'b0;
        step();
        drain();
        chk("sweep_ignored", 32'(sweep_xfers), 32'(NPAIR));
`endif

        idle_inputs();
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
